// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions: datapath width, canonical NOP, base opcodes
// and the fetch-stage state encoding.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [1:0] {
        FETCH_IDLE    = 2'd0,
        FETCH_REQ     = 2'd1,
        FETCH_DISCARD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/instr_queue.sv
// Small synchronous FIFO of fetched {instr, pc} pairs between imem and the IF/ID register.
// DEPTH must be a power of two so the pointers wrap naturally.
module instr_queue #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned XLEN  = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [31:0]              push_instr,
    input  logic [XLEN-1:0]          push_pc,
    input  logic                     pop,
    input  logic                     clear,
    output logic [31:0]              head_instr,
    output logic [XLEN-1:0]          head_pc,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [31:0]     instr_mem [DEPTH];
    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            push_en;
    logic            pop_en;

    assign push_en    = push && !clear;
    assign pop_en     = pop && !clear && (count != '0);
    assign empty      = (count == '0);
    assign head_instr = instr_mem[rd_ptr];
    assign head_pc    = pc_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_en) begin
            instr_mem[wr_ptr] <= push_instr;
            pc_mem[wr_ptr]    <= push_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, push_en} - {{AW{1'b0}}, pop_en};
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction fetch: fetch PC, req/ack imem handshake with redirect discard,
// instruction queue and the IF/ID pipeline register feeding decode.
module fetch_stage #(
    parameter int unsigned     XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     QDEPTH   = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imemReq,
    output logic [XLEN-1:0] imemAddr,
    input  logic            imemAck,
    input  logic [31:0]     imemRdata,
    input  logic            stallD,
    input  logic            flushD,
    input  logic            pcSrcE,
    input  logic [XLEN-1:0] pcTargetE,
    output logic [31:0]     instrD,
    output logic [XLEN-1:0] pcD,
    output logic [XLEN-1:0] pcPlus4D,
    output logic            validD
);
    import riscv_pkg::*;

    localparam int unsigned     CW    = $clog2(QDEPTH) + 1;
    localparam logic [CW-1:0]   QFULL = CW'(QDEPTH);

    fetch_state_e    state;
    logic [XLEN-1:0] pcF;
    logic [XLEN-1:0] redirPc;
    logic [XLEN-1:0] target;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_next;
    logic            empty;
    logic [31:0]     head_instr;
    logic [XLEN-1:0] head_pc;
    logic            push;
    logic            pop;

    assign target     = pcTargetE & ~XLEN'(3);
    assign imemReq    = (state != FETCH_IDLE);
    assign imemAddr   = pcF;
    assign push       = (state == FETCH_REQ) && imemAck && !pcSrcE;
    assign pop        = !pcSrcE && !flushD && !stallD && !empty;
    assign count_next = count + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};

    instr_queue #(
        .DEPTH (QDEPTH),
        .XLEN  (XLEN)
    ) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_instr (imemRdata),
        .push_pc    (pcF),
        .pop        (pop),
        .clear      (pcSrcE),
        .head_instr (head_instr),
        .head_pc    (head_pc),
        .count      (count),
        .empty      (empty)
    );

    // imemAddr must stay put while a request is outstanding, so a redirect
    // without ack parks the target in redirPc until the stale word returns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= FETCH_IDLE;
            pcF     <= RESET_PC;
            redirPc <= RESET_PC;
        end else begin
            unique case (state)
                FETCH_IDLE: begin
                    if (pcSrcE) pcF <= target;
                    if (pcSrcE || count < QFULL) state <= FETCH_REQ;
                end
                FETCH_REQ: begin
                    if (pcSrcE && !imemAck) begin
                        redirPc <= target;
                        state   <= FETCH_DISCARD;
                    end else if (pcSrcE) begin
                        pcF <= target;
                    end else if (imemAck) begin
                        pcF <= pcF + XLEN'(4);
                        if (count_next >= QFULL) state <= FETCH_IDLE;
                    end
                end
                FETCH_DISCARD: begin
                    if (imemAck) begin
                        pcF   <= pcSrcE ? target : redirPc;
                        state <= FETCH_REQ;
                    end else if (pcSrcE) begin
                        redirPc <= target;
                    end
                end
                default: state <= FETCH_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instrD   <= NOP_INSTR;
            pcD      <= '0;
            pcPlus4D <= '0;
            validD   <= 1'b0;
        end else if (pcSrcE || flushD) begin
            instrD <= NOP_INSTR;
            validD <= 1'b0;
        end else if (!stallD) begin
            if (!empty) begin
                instrD   <= head_instr;
                pcD      <= head_pc;
                pcPlus4D <= head_pc + XLEN'(4);
                validD   <= 1'b1;
            end else begin
                instrD <= NOP_INSTR;
                validD <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: streaming, back-pressure, redirects, flush/stall,
// async reset and PC wrap, against hand-derived cycle-by-cycle expectations.
module tb_fetch_stage;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemAck;
    logic [31:0] imemRdata;
    logic        stallD = 1'b0;
    logic        flushD = 1'b0;
    logic        pcSrcE = 1'b0;
    logic [31:0] pcTargetE = '0;
    logic [31:0] instrD;
    logic [31:0] pcD;
    logic [31:0] pcPlus4D;
    logic        validD;

    logic        mem_auto = 1'b1;
    int unsigned mem_lat = 0;
    int unsigned wait_cnt = 0;
    logic        auto_ack = 1'b0;
    logic [31:0] auto_rdata = '0;
    logic        man_ack = 1'b0;
    logic [31:0] man_rdata = '0;

    int unsigned n_checks = 0;
    int unsigned n_fail = 0;

    always #5 clk = ~clk;

    assign imemAck   = mem_auto ? auto_ack : man_ack;
    assign imemRdata = mem_auto ? auto_rdata : man_rdata;

    fetch_stage #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0100),
        .QDEPTH   (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .imemReq   (imemReq),
        .imemAddr  (imemAddr),
        .imemAck   (imemAck),
        .imemRdata (imemRdata),
        .stallD    (stallD),
        .flushD    (flushD),
        .pcSrcE    (pcSrcE),
        .pcTargetE (pcTargetE),
        .instrD    (instrD),
        .pcD       (pcD),
        .pcPlus4D  (pcPlus4D),
        .validD    (validD)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A00_0000;
    endfunction

    // Memory model: ack after mem_lat idle request cycles, evaluated mid-cycle.
    always @(negedge clk) begin
        if (!rst_n || !mem_auto || !imemReq) begin
            auto_ack = 1'b0;
            wait_cnt = 0;
        end else if (wait_cnt == mem_lat) begin
            auto_ack   = 1'b1;
            auto_rdata = mem_word(imemAddr);
            wait_cnt   = 0;
        end else begin
            auto_ack = 1'b0;
            wait_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        #2;
    endtask

    // Leaves the bench just before the first post-reset rising edge.
    task automatic apply_reset();
        stallD    = 1'b0;
        flushD    = 1'b0;
        pcSrcE    = 1'b0;
        pcTargetE = '0;
        man_ack   = 1'b0;
        rst_n     = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        // 1: zero-wait streaming
        mem_auto = 1'b1;
        mem_lat  = 0;
        apply_reset();
        check("rst_req", imemReq, 0);
        check("rst_valid", validD, 0);
        check("rst_instr", instrD, NOP_INSTR);
        check("rst_pcD", pcD, 0);
        check("rst_pc4", pcPlus4D, 0);
        for (int k = 1; k <= 6; k++) begin
            cyc();
            check("s1_req", imemReq, 1);
            check("s1_addr", imemAddr, 32'h100 + 32'(4 * (k - 1)));
            if (k >= 3) begin
                check("s1_valid", validD, 1);
                check("s1_pcD", pcD, 32'h100 + 32'(4 * (k - 3)));
                check("s1_pc4", pcPlus4D, 32'h104 + 32'(4 * (k - 3)));
                check("s1_instr", instrD, mem_word(32'h100 + 32'(4 * (k - 3))));
            end else begin
                check("s1_bubble", validD, 0);
            end
        end

        // 2: latency 3 with decode stalled until the queue fills
        mem_lat = 3;
        apply_reset();
        stallD = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            if (k == 4) check("s2_addr0", imemAddr, 32'h100);
            if (k == 5) check("s2_addr1", imemAddr, 32'h104);
            if (k <= 8) check("s2_req_on", imemReq, 1);
            else        check("s2_req_off", imemReq, 0);
            check("s2_hold_valid", validD, 0);
            check("s2_hold_pcD", pcD, 0);
        end
        stallD = 1'b0;
        cyc();
        check("s2_v0", validD, 1);
        check("s2_pc0", pcD, 32'h100);
        check("s2_i0", instrD, mem_word(32'h100));
        check("s2_idle", imemReq, 0);
        cyc();
        check("s2_v1", validD, 1);
        check("s2_pc1", pcD, 32'h104);
        check("s2_restart", imemReq, 1);
        check("s2_addr2", imemAddr, 32'h108);
        cyc();
        check("s2_drain", validD, 0);

        // 3: redirect while request pending, no ack
        mem_auto = 1'b0;
        apply_reset();
        cyc();
        check("s3_a0", imemAddr, 32'h100);
        man_ack = 1'b1; man_rdata = mem_word(32'h100);
        cyc();
        check("s3_a1", imemAddr, 32'h104);
        man_rdata = mem_word(32'h104);
        cyc();
        check("s3_v", validD, 1);
        check("s3_pcD", pcD, 32'h100);
        check("s3_a2", imemAddr, 32'h108);
        man_ack = 1'b0; pcSrcE = 1'b1; pcTargetE = 32'h200;
        cyc();
        pcSrcE = 1'b0;
        check("s3_disc_req", imemReq, 1);
        check("s3_disc_addr", imemAddr, 32'h108);
        check("s3_bubble", validD, 0);
        check("s3_nop", instrD, NOP_INSTR);
        check("s3_pcD_hold", pcD, 32'h100);
        cyc();
        check("s3_disc_addr2", imemAddr, 32'h108);
        check("s3_q_cleared", validD, 0);
        man_ack = 1'b1; man_rdata = 32'hDEAD_BEEF;
        cyc();
        check("s3_new_addr", imemAddr, 32'h200);
        check("s3_dropped", validD, 0);
        man_rdata = mem_word(32'h200);
        cyc();
        man_ack = 1'b0;
        check("s3_addr_next", imemAddr, 32'h204);
        cyc();
        check("s3_v2", validD, 1);
        check("s3_pc2", pcD, 32'h200);
        check("s3_i2", instrD, mem_word(32'h200));

        // 4: redirect coincident with ack, target low bits forced to zero
        apply_reset();
        cyc();
        man_ack = 1'b1; man_rdata = mem_word(32'h100);
        cyc();
        check("s4_a1", imemAddr, 32'h104);
        man_rdata = mem_word(32'h104); pcSrcE = 1'b1; pcTargetE = 32'h202;
        cyc();
        pcSrcE = 1'b0;
        check("s4_req", imemReq, 1);
        check("s4_addr", imemAddr, 32'h200);
        check("s4_bubble", validD, 0);
        check("s4_nop", instrD, NOP_INSTR);
        check("s4_pcD", pcD, 0);
        man_rdata = mem_word(32'h200);
        cyc();
        man_ack = 1'b0;
        check("s4_addr2", imemAddr, 32'h204);
        check("s4_q_cleared", validD, 0);
        cyc();
        check("s4_v", validD, 1);
        check("s4_pcD2", pcD, 32'h200);
        check("s4_pc4", pcPlus4D, 32'h204);
        check("s4_instr", instrD, mem_word(32'h200));

        // 5: flush+stall, then flush alone with a queued entry
        apply_reset();
        cyc();
        man_ack = 1'b1; man_rdata = mem_word(32'h100);
        cyc();
        man_rdata = mem_word(32'h104);
        cyc();
        check("s5_v0", validD, 1);
        check("s5_pc0", pcD, 32'h100);
        man_ack = 1'b0; flushD = 1'b1; stallD = 1'b1;
        cyc();
        check("s5_fs_valid", validD, 0);
        check("s5_fs_nop", instrD, 32'h0000_0013);
        check("s5_fs_pcD", pcD, 32'h100);
        check("s5_fs_pc4", pcPlus4D, 32'h104);
        stallD = 1'b0;
        cyc();
        check("s5_f_valid", validD, 0);
        flushD = 1'b0;
        cyc();
        check("s5_nopop_v", validD, 1);
        check("s5_nopop_pc", pcD, 32'h104);
        check("s5_nopop_i", instrD, mem_word(32'h104));

        // 6: async reset while in DISCARD
        apply_reset();
        cyc();
        man_ack = 1'b1; man_rdata = mem_word(32'h100);
        cyc();
        man_rdata = mem_word(32'h104);
        cyc();
        man_ack = 1'b0; pcSrcE = 1'b1; pcTargetE = 32'h300;
        cyc();
        pcSrcE = 1'b0;
        check("s6_disc_addr", imemAddr, 32'h108);
        rst_n = 1'b0;
        #1;
        check("s6_rst_req", imemReq, 0);
        check("s6_rst_valid", validD, 0);
        check("s6_rst_pcD", pcD, 0);
        check("s6_rst_instr", instrD, NOP_INSTR);
        mem_auto = 1'b1;
        mem_lat  = 0;
        cyc();
        rst_n = 1'b1;
        cyc();
        check("s6_restart0", imemAddr, 32'h100);
        cyc();
        check("s6_restart1", imemAddr, 32'h104);
        cyc();
        check("s6_pcD", pcD, 32'h100);

        // 7: PC wraps past the top of the address space
        apply_reset();
        cyc();
        pcSrcE = 1'b1; pcTargetE = 32'hFFFF_FFF8;
        cyc();
        pcSrcE = 1'b0;
        check("s7_a0", imemAddr, 32'hFFFF_FFF8);
        cyc();
        check("s7_a1", imemAddr, 32'hFFFF_FFFC);
        cyc();
        check("s7_wrap", imemAddr, 32'h0);
        check("s7_pcD0", pcD, 32'hFFFF_FFF8);
        cyc();
        check("s7_pcD1", pcD, 32'hFFFF_FFFC);
        check("s7_pc4_wrap", pcPlus4D, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
